// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bus of the PISO serializer: a valid/ready parallel
// side and a framed serial side.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] pi;
    logic             pi_valid;
    logic             pi_ready;
    logic             so;
    logic             so_valid;
    logic             so_sof;
    logic             so_eof;
    logic             busy;

    // master: the word producer and serial consumer; slave: the serializer
    modport master (
        output pi, pi_valid,
        input  pi_ready, so, so_valid, so_sof, so_eof, busy
    );
    modport slave (
        input  pi, pi_valid,
        output pi_ready, so, so_valid, so_sof, so_eof, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: takes a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per clock, gapless across back-to-back words.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    piso_serializer_if.slave    bus
);
    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             accept;

    assign last   = (cnt == LAST);
    // A new word may land on the final bit cycle, which keeps words gapless.
    assign bus.pi_ready = rst && ((state == IDLE) || last);
    assign accept       = bus.pi_valid && bus.pi_ready;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= bus.pi;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        if (accept) begin
                            shreg <= bus.pi;
                            cnt   <= '0;
                        end else begin
                            shreg <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        if (MSB_FIRST) shreg <= {shreg[WIDTH-2:0], 1'b0};
                        else           shreg <= {1'b0, shreg[WIDTH-1:1]};
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Serial side is decoded purely from registers: no pi-to-so path.
    assign bus.so       = (state == SHIFT) && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign bus.so_valid = (state == SHIFT);
    assign bus.busy     = (state == SHIFT);
    assign bus.so_sof   = (state == SHIFT) && (cnt == '0);
    assign bus.so_eof   = (state == SHIFT) && last;
endmodule
